nibble_serial_add_ctrl: RTL

Upstream sequencer that drives the team's existing 4-bit registered ripple-carry adder stage. That stage has 4-bit A/B operands, a carry-in, an enable, and a 5-bit registered output with 1-cycle latency. This block turns a wide add into nibble-serial adds: it latches two wide operands, feeds one nibble per step, chains the carry from add_q[4] into the next nibble, and assembles the wide sum. The adder stage is instantiated alongside this block, at the same level; it is not inside it.

---
 rtl/nibble_add_pkg.sv | 21 ++
 rtl/nibble_serial_add_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial add sequencer: nibble width,
// FSM state encoding and the index-width helper.
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences a wide add as NIBBLES back-to-back 4-bit adds on the external
// registered adder stage, chaining its carry-out into the next nibble.
//
// state   | meaning
// IDLE    | waiting for start; sum/cout hold the last result
// ISSUE   | add_* drive one nibble, add_en high for this cycle
// CAPTURE | add_q holds that nibble's result; store it, issue next or finish
// DONE    | done pulse, sum/cout valid
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  input  logic                         cin,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout,
  output logic [NIBBLE_W-1:0]          add_a,
  output logic [NIBBLE_W-1:0]          add_b,
  output logic                         add_cin,
  output logic                         add_en,
  input  logic [NIBBLE_W:0]            add_q
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? clog2(NIBBLES) : 1;
  localparam int LAST  = NIBBLES - 1;

  typedef logic [IDX_W-1:0] idx_t;

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  idx_t           idx;
  idx_t           idx_next;

  assign idx_next = idx + idx_t'(1);

  // The registered add_cin is the running carry: it is loaded with cin on
  // accept and with add_q[4] on every non-final capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      add_en  <= 1'b0;
    end else begin
      done    <= 1'b0;
      add_en  <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            idx     <= '0;
            busy    <= 1'b1;
            add_a   <= a[NIBBLE_W-1:0];
            add_b   <= b[NIBBLE_W-1:0];
            add_cin <= cin;
            add_en  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          sum[NIBBLE_W*idx +: NIBBLE_W] <= add_q[NIBBLE_W-1:0];
          if (idx == idx_t'(LAST)) begin
            cout  <= add_q[NIBBLE_W];
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx     <= idx_next;
            add_a   <= a_reg[NIBBLE_W*idx_next +: NIBBLE_W];
            add_b   <= b_reg[NIBBLE_W*idx_next +: NIBBLE_W];
            add_cin <= add_q[NIBBLE_W];
            add_en  <= 1'b1;
            state   <= ISSUE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
